uart_rx: RTL and testbench
==========================

# uart_rx

Serial receive engine for the UART. Sits directly downstream of the baud clock generator: consumes its `voting_edge` / `sample_edge` strobes, drives its `sample_clk_clr` to align the sample grid to each start bit, and deserialises the `rxd` line into characters with parity, framing, break and overrun status. Completed characters are pushed to the receive FIFO through a single-cycle write strobe.

## Interface
Parameters:
- `SYNC_STAGES`, 2, number of flops in the `rxd` metastability synchroniser (≥2).

Ports:
- `pclk`  in  1  system clock; all logic on the rising edge.
- `presetn`  in  1  reset, asynchronous and active-low.
- `rxd`  in  1  serial input, idle high, asynchronous to `pclk`.
- `voting_edge`  in  1  one-cycle strobe; three per bit period (ticks 6, 7, 8 of 16).
- `sample_edge`  in  1  one-cycle strobe; one per bit period (tick 9), after the three votes.
- `wls`  in  2  word length select: 00=5, 01=6, 10=7, 11=8 data bits.
- `pen`  in  1  parity enable.
- `eps`  in  1  even parity select.
- `sp`  in  1  stick parity.
- `rx_fifo_full`  in  1  receive FIFO cannot accept a push.
- `sample_clk_clr`  out  1  one-cycle pulse that restarts the receive baud counter.
- `rx_push`  out  1  one-cycle write strobe to the receive FIFO.
- `rx_data`  out  8  received character, LSB = first bit; unused upper bits 0.
- `parity_err`, `framing_err`, `break_int`  out  1 each  status for the character on `rx_data`; valid with `rx_push`.
- `overrun_err`  out  1  one-cycle pulse: character completed while `rx_fifo_full`=1.
- `rx_busy`  out  1  high in every state except IDLE.

## Operation
- `rxd` passes through a `SYNC_STAGES` flop chain (reset value 1), then one more flop for edge detection. A falling edge is sync=0 with the previous value 1.
- Votes: a 2-bit counter counts ones seen on the synchronised line at each `voting_edge`. It clears at every `sample_edge` and at every `sample_clk_clr`. The bit value is majority: count ≥ 2.
- `wls`, `pen`, `eps`, `sp` are latched when the start bit is accepted. Changes mid-frame have no effect until the next frame.
- FSM states:
  - IDLE: on a falling edge, pulse `sample_clk_clr` and go to START.
  - START: at `sample_edge`, majority 0 goes to DATA with bit index 0; majority 1 is a false start and returns to IDLE with no push.
  - DATA: at each `sample_edge`, shift the majority bit into position `index`. After the last bit of word length (5..8), go to PARITY if `pen`=1, otherwise to STOP.
  - PARITY: at `sample_edge`, capture the parity bit and go to STOP.
  - STOP: at `sample_edge`, evaluate the frame and return to IDLE. Exactly one stop bit is checked regardless of the stop-bit setting.
- Parity expected value:
  - `sp`=0: `eps`=1 expects XOR of the data bits; `eps`=0 expects its inverse.
  - `sp`=1: expects `~eps`.
  - `parity_err` = received ≠ expected, forced 0 when `pen`=0.
- `framing_err` = stop bit sampled 0.
- `break_int` = all data bits, the parity bit (if enabled) and the stop bit are 0. A break also sets `framing_err`, and `rx_data` = 0x00.
- After STOP the FSM re-arms only on a new high-to-low edge, so a line held low (break) produces exactly one character.
- Overrun: if `rx_fifo_full`=1 when a push is due, `rx_push` stays 0 and `overrun_err` pulses. `rx_data` and status still update.

## Timing
- Reset values: `sample_clk_clr`, `rx_push`, `overrun_err`, `parity_err`, `framing_err`, `break_int`, `rx_busy` = 0; `rx_data` = 0x00; FSM = IDLE.
- `rxd` to the synchronised value takes `SYNC_STAGES` cycles. `sample_clk_clr` is registered and rises on the cycle after the falling edge is seen on the synchronised line.
- `rx_push` / `overrun_err` are high the cycle after the STOP-state `sample_edge`. `rx_data` and the status bits are stable from that cycle until the next push.
- `voting_edge` or `sample_edge` arriving in the same cycle as `sample_clk_clr` is ignored.
- `rx_busy` rises with `sample_clk_clr` and falls in the same cycle `rx_push` is high.
- Deasserting `presetn` mid-frame aborts immediately: no push, everything returns to reset values.

## Test plan
- 8N1 (`wls`=11, `pen`=0), byte 0xA5, divisor giving 16 ticks/bit -> one `rx_push`, `rx_data`=0xA5, all status bits 0, `sample_clk_clr` pulses once.
- 7E1 (`wls`=10, `pen`=1, `eps`=1), data 0x35 sent with a wrong parity bit of 1 -> `rx_data`=0x35, `parity_err`=1; the same frame with correct parity 0 gives `parity_err`=0.
- Start pulse low for only 4 ticks (covering votes 6 and 7 low is not reached; the line is high at all three votes) -> no `rx_push`, FSM back in IDLE, the next valid 0x3C is received correctly.
- One vote of each data bit corrupted for 0x5A -> `rx_data`=0x5A, no errors.
- `rxd` held low for 3 frame times -> exactly one push with `rx_data`=0x00, `break_int`=1, `framing_err`=1; no further push until `rxd` rises and falls again.
- `rx_fifo_full`=1 at the end of a frame -> `rx_push`=0, `overrun_err` pulses for 1 cycle. Asserting `presetn`=0 mid-DATA -> no push, outputs return to reset values.

Source files
------------

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - receive-FIFO push bus between uart_rx and its FIFO
interface uart_rx_if;
  logic       rx_push;
  logic [7:0] rx_data;
  logic       parity_err;
  logic       framing_err;
  logic       break_int;
  logic       overrun_err;
  logic       rx_fifo_full;

  modport master (
    output rx_push, rx_data, parity_err, framing_err, break_int, overrun_err,
    input  rx_fifo_full
  );

  modport slave (
    input  rx_push, rx_data, parity_err, framing_err, break_int, overrun_err,
    output rx_fifo_full
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receive engine: 3-vote majority sampling, parity/framing/break/overrun status
module uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       rxd,
  input  logic       voting_edge,
  input  logic       sample_edge,
  input  logic [1:0] wls,
  input  logic       pen,
  input  logic       eps,
  input  logic       sp,
  output logic       sample_clk_clr,
  output logic       rx_busy,
  uart_rx_if.master  fifo
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_s;
  logic                   rxd_d;
  logic                   fall;
  logic [1:0]             vote_cnt;
  logic                   majority;
  logic                   ve;
  logic                   se;
  logic [2:0]             bit_idx;
  logic [2:0]             last_idx;
  logic [7:0]             shreg;
  logic                   par_bit;
  logic [1:0]             wls_l;
  logic                   pen_l;
  logic                   eps_l;
  logic                   sp_l;
  logic                   exp_par;

  assign rxd_s    = sync_q[SYNC_STAGES-1];
  assign fall     = rxd_d & ~rxd_s;
  assign majority = vote_cnt[1];
  // Strobes coinciding with the grid restart belong to the old grid.
  assign ve       = voting_edge & ~sample_clk_clr;
  assign se       = sample_edge & ~sample_clk_clr;
  assign last_idx = {1'b0, wls_l} + 3'd4;
  assign exp_par  = sp_l ? ~eps_l : (eps_l ? ^shreg : ~(^shreg));

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      sync_q <= '1;
      rxd_d  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
      rxd_d  <= rxd_s;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      vote_cnt <= 2'd0;
    end else if (se || sample_clk_clr) begin
      vote_cnt <= 2'd0;
    end else if (ve && rxd_s && vote_cnt != 2'd3) begin
      vote_cnt <= vote_cnt + 2'd1;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state            <= ST_IDLE;
      sample_clk_clr   <= 1'b0;
      rx_busy          <= 1'b0;
      bit_idx          <= 3'd0;
      shreg            <= 8'h00;
      par_bit          <= 1'b0;
      wls_l            <= 2'b00;
      pen_l            <= 1'b0;
      eps_l            <= 1'b0;
      sp_l             <= 1'b0;
      fifo.rx_push     <= 1'b0;
      fifo.overrun_err <= 1'b0;
      fifo.rx_data     <= 8'h00;
      fifo.parity_err  <= 1'b0;
      fifo.framing_err <= 1'b0;
      fifo.break_int   <= 1'b0;
    end else begin
      sample_clk_clr   <= 1'b0;
      fifo.rx_push     <= 1'b0;
      fifo.overrun_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Only a fresh high-to-low edge arms a frame, so a held-low line yields one character.
          if (fall) begin
            sample_clk_clr <= 1'b1;
            rx_busy        <= 1'b1;
            wls_l          <= wls;
            pen_l          <= pen;
            eps_l          <= eps;
            sp_l           <= sp;
            state          <= ST_START;
          end
        end
        ST_START: begin
          if (se) begin
            if (majority) begin
              rx_busy <= 1'b0;
              state   <= ST_IDLE;
            end else begin
              bit_idx <= 3'd0;
              shreg   <= 8'h00;
              par_bit <= 1'b0;
              state   <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (se) begin
            shreg[bit_idx] <= majority;
            if (bit_idx == last_idx) begin
              state <= pen_l ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        ST_PARITY: begin
          if (se) begin
            par_bit <= majority;
            state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (se) begin
            fifo.rx_data     <= shreg;
            fifo.parity_err  <= pen_l & (par_bit != exp_par);
            fifo.framing_err <= ~majority;
            fifo.break_int   <= (shreg == 8'h00) & ~(pen_l & par_bit) & ~majority;
            fifo.rx_push     <= ~fifo.rx_fifo_full;
            fifo.overrun_err <= fifo.rx_fifo_full;
            rx_busy          <= 1'b0;
            state            <= ST_IDLE;
          end
        end
        default: begin
          rx_busy <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx with a 16-tick/bit baud model
module tb_uart_rx;
  logic       pclk;
  logic       presetn;
  logic       rxd;
  logic [1:0] wls;
  logic       pen;
  logic       eps;
  logic       sp;
  logic       sample_clk_clr;
  logic       rx_busy;
  logic       voting_edge;
  logic       sample_edge;

  uart_rx_if fifo ();

  uart_rx #(.SYNC_STAGES(2)) dut (
    .pclk          (pclk),
    .presetn       (presetn),
    .rxd           (rxd),
    .voting_edge   (voting_edge),
    .sample_edge   (sample_edge),
    .wls           (wls),
    .pen           (pen),
    .eps           (eps),
    .sp            (sp),
    .sample_clk_clr(sample_clk_clr),
    .rx_busy       (rx_busy),
    .fifo          (fifo)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Baud model: one tick every 2 pclk, 16 ticks per bit, restarted by sample_clk_clr.
  logic       div_q;
  logic [3:0] tick_q;
  always @(posedge pclk) begin
    if (sample_clk_clr) begin
      div_q  <= 1'b0;
      tick_q <= 4'd0;
    end else begin
      div_q <= ~div_q;
      if (div_q) tick_q <= tick_q + 4'd1;
    end
  end
  assign voting_edge = !div_q && (tick_q >= 4'd6) && (tick_q <= 4'd8);
  assign sample_edge = !div_q && (tick_q == 4'd9);

  int push_cnt = 0;
  int ovr_cnt  = 0;
  int clr_cnt  = 0;
  always @(negedge pclk) begin
    if (fifo.rx_push)     push_cnt++;
    if (fifo.overrun_err) ovr_cnt++;
    if (sample_clk_clr)   clr_cnt++;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One bit period = 32 pclk; k==15 lands on the first vote of the bit.
  task automatic drive_bit(input logic v, input bit corrupt);
    for (int k = 1; k <= 32; k++) begin
      @(negedge pclk);
      rxd = (corrupt && k == 15) ? ~v : v;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input bit with_par,
                            input logic par, input bit corrupt);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(d[i], corrupt);
    if (with_par) drive_bit(par, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
  endtask

  int p0, o0, c0;

  initial begin
    presetn = 1'b0;
    rxd     = 1'b1;
    wls     = 2'b11;
    pen     = 1'b0;
    eps     = 1'b0;
    sp      = 1'b0;
    fifo.rx_fifo_full = 1'b0;
    repeat (4) @(negedge pclk);
    check("rst_clr",    {31'd0, sample_clk_clr}, 32'd0);
    check("rst_push",   {31'd0, fifo.rx_push}, 32'd0);
    check("rst_data",   {24'd0, fifo.rx_data}, 32'h00);
    check("rst_status", {28'd0, fifo.parity_err, fifo.framing_err, fifo.break_int, fifo.overrun_err}, 32'd0);
    check("rst_busy",   {31'd0, rx_busy}, 32'd0);
    presetn = 1'b1;
    repeat (40) @(negedge pclk);

    // 8N1 0xA5
    p0 = push_cnt; c0 = clr_cnt;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0);
    check("8n1_push",   push_cnt - p0, 1);
    check("8n1_clr",    clr_cnt - c0, 1);
    check("8n1_data",   {24'd0, fifo.rx_data}, 32'hA5);
    check("8n1_status", {29'd0, fifo.parity_err, fifo.framing_err, fifo.break_int}, 32'd0);
    check("8n1_busy",   {31'd0, rx_busy}, 32'd0);

    // 7E1 0x35: even parity bit should be 0
    wls = 2'b10; pen = 1'b1; eps = 1'b1;
    send_frame(8'h35, 7, 1'b1, 1'b1, 1'b0);
    check("7e1_bad_data", {24'd0, fifo.rx_data}, 32'h35);
    check("7e1_bad_perr", {31'd0, fifo.parity_err}, 32'd1);
    send_frame(8'h35, 7, 1'b1, 1'b0, 1'b0);
    check("7e1_ok_perr",  {31'd0, fifo.parity_err}, 32'd0);
    check("7e1_ok_ferr",  {31'd0, fifo.framing_err}, 32'd0);

    // 5-bit stick parity with eps=0 expects a 1 parity bit
    wls = 2'b00; pen = 1'b1; eps = 1'b0; sp = 1'b1;
    send_frame(8'h13, 5, 1'b1, 1'b1, 1'b0);
    check("5s_data", {24'd0, fifo.rx_data}, 32'h13);
    check("5s_perr", {31'd0, fifo.parity_err}, 32'd0);
    wls = 2'b11; pen = 1'b0; eps = 1'b0; sp = 1'b0;

    // False start: low for 4 ticks only
    p0 = push_cnt;
    for (int k = 0; k < 8; k++) begin @(negedge pclk); rxd = 1'b0; end
    @(negedge pclk); rxd = 1'b1;
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    check("fs_push", push_cnt - p0, 0);
    check("fs_busy", {31'd0, rx_busy}, 32'd0);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0);
    check("fs_next_push", push_cnt - p0, 1);
    check("fs_next_data", {24'd0, fifo.rx_data}, 32'h3C);

    // One corrupted vote per data bit
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
    check("vote_data",   {24'd0, fifo.rx_data}, 32'h5A);
    check("vote_status", {29'd0, fifo.parity_err, fifo.framing_err, fifo.break_int}, 32'd0);

    // Break: low for 3 frame times
    p0 = push_cnt;
    for (int k = 0; k < 960; k++) begin @(negedge pclk); rxd = 1'b0; end
    check("brk_push", push_cnt - p0, 1);
    check("brk_data", {24'd0, fifo.rx_data}, 32'h00);
    check("brk_int",  {31'd0, fifo.break_int}, 32'd1);
    check("brk_ferr", {31'd0, fifo.framing_err}, 32'd1);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    check("brk_after_push", push_cnt - p0, 1);

    // Overrun
    p0 = push_cnt; o0 = ovr_cnt;
    fifo.rx_fifo_full = 1'b1;
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0);
    check("ovr_push", push_cnt - p0, 0);
    check("ovr_cyc",  ovr_cnt - o0, 1);
    check("ovr_data", {24'd0, fifo.rx_data}, 32'h11);
    fifo.rx_fifo_full = 1'b0;

    // Reset mid-DATA
    p0 = push_cnt; o0 = ovr_cnt;
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    check("mid_busy", {31'd0, rx_busy}, 32'd1);
    @(negedge pclk); presetn = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, rx_busy}, 32'd0);
    check("mid_rst_data", {24'd0, fifo.rx_data}, 32'h00);
    check("mid_rst_clr",  {31'd0, sample_clk_clr}, 32'd0);
    repeat (3) @(negedge pclk);
    rxd = 1'b1;
    presetn = 1'b1;
    for (int i = 0; i < 10; i++) drive_bit(1'b1, 1'b0);
    check("mid_push", push_cnt - p0, 0);
    check("mid_ovr",  ovr_cnt - o0, 0);
    check("mid_idle_busy", {31'd0, rx_busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
